// File: rtl/vga_if_timing_pkg.sv
// Shared 1024x768@60 timing constants and sync bundle type for the VGA path.
package vga_if_timing_pkg;

  localparam int unsigned CNT_W = 11;

  localparam int unsigned H_ACTIVE = 1024;
  localparam int unsigned H_FP     = 24;
  localparam int unsigned H_SYNC   = 136;
  localparam int unsigned H_BP     = 160;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 768;
  localparam int unsigned V_FP     = 3;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BP     = 29;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Bit order matches the 3-bit delay line: {en, vs, hs}.
  typedef struct packed {
    logic en;
    logic vs;
    logic hs;
  } sync_t;

endpackage

// File: rtl/vga_if_timing_sync_dly.sv
// Fixed-depth delay line for the {en, vs, hs} timing bundle.
module vga_if_timing_sync_dly #(
  parameter int unsigned p_DEPTH   = 3,
  parameter logic [2:0]  p_RST_VAL = '0
) (
  input  logic       VGA_CLK,
  input  logic       RST_N,
  input  logic [2:0] i_d,
  output logic [2:0] o_q,
  output logic       o_tap_en
);

  logic [2:0] r_stg [p_DEPTH];

  // Shift register; every stage resets to the inactive bundle value.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < p_DEPTH; i++) r_stg[i] <= p_RST_VAL;
    end else begin
      r_stg[0] <= i_d;
      for (int unsigned i = 1; i < p_DEPTH; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_q      = r_stg[p_DEPTH-1];
  // Enable one stage early: gates the pixel register so data lands with o_q.
  assign o_tap_en = r_stg[p_DEPTH-2][2];

endmodule

// File: rtl/vga_if_timing.sv
// Free-running VGA timing generator with pipelined pixel request/return alignment.
module vga_if_timing
  import vga_if_timing_pkg::*;
#(
  parameter int unsigned p_H_ACTIVE = H_ACTIVE,
  parameter int unsigned p_H_FP     = H_FP,
  parameter int unsigned p_H_SYNC   = H_SYNC,
  parameter int unsigned p_H_BP     = H_BP,
  parameter int unsigned p_V_ACTIVE = V_ACTIVE,
  parameter int unsigned p_V_FP     = V_FP,
  parameter int unsigned p_V_SYNC   = V_SYNC,
  parameter int unsigned p_V_BP     = V_BP,
  parameter int unsigned p_SYNC_POL = 0,
  parameter int unsigned p_PIPE_DLY = 2
) (
  input  logic        VGA_CLK,
  input  logic        RST_N,
  input  logic [23:0] VGA_BUF_RGB,
  output logic        VGA_IF_RGBEN,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int unsigned LP_H_TOT = p_H_ACTIVE + p_H_FP + p_H_SYNC + p_H_BP;
  localparam int unsigned LP_V_TOT = p_V_ACTIVE + p_V_FP + p_V_SYNC + p_V_BP;

  localparam logic [CNT_W-1:0] LP_H_LAST = CNT_W'(LP_H_TOT - 1);
  localparam logic [CNT_W-1:0] LP_V_LAST = CNT_W'(LP_V_TOT - 1);
  localparam logic [CNT_W-1:0] LP_H_ACT  = CNT_W'(p_H_ACTIVE);
  localparam logic [CNT_W-1:0] LP_V_ACT  = CNT_W'(p_V_ACTIVE);
  localparam logic [CNT_W-1:0] LP_HS_BEG = CNT_W'(p_H_ACTIVE + p_H_FP);
  localparam logic [CNT_W-1:0] LP_HS_END = CNT_W'(p_H_ACTIVE + p_H_FP + p_H_SYNC - 1);
  localparam logic [CNT_W-1:0] LP_VS_BEG = CNT_W'(p_V_ACTIVE + p_V_FP);
  localparam logic [CNT_W-1:0] LP_VS_END = CNT_W'(p_V_ACTIVE + p_V_FP + p_V_SYNC - 1);
  localparam logic             LP_POL    = 1'(p_SYNC_POL);
  localparam sync_t            LP_IDLE   = '{en: 1'b0, vs: ~LP_POL, hs: ~LP_POL};

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_h_wrap;
  sync_t            w_raw_nxt;
  sync_t            r_raw;
  sync_t            w_dly;
  logic             w_tap_en;
  logic [23:0]      r_rgb;

  // Next counter position; raw timing is decoded from it so the registered
  // enable/syncs line up with the counter value of the same cycle.
  always_comb begin
    w_h_wrap = (r_h_cnt == LP_H_LAST);
    w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) w_v_nxt = (r_v_cnt == LP_V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
    w_raw_nxt.en = (w_h_nxt < LP_H_ACT) && (w_v_nxt < LP_V_ACT);
    w_raw_nxt.hs = ((w_h_nxt >= LP_HS_BEG) && (w_h_nxt <= LP_HS_END)) ~^ LP_POL;
    w_raw_nxt.vs = ((w_v_nxt >= LP_VS_BEG) && (w_v_nxt <= LP_VS_END)) ~^ LP_POL;
  end

  // Counters reset to the last position so the first edge lands on (0,0).
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_h_cnt <= LP_H_LAST;
      r_v_cnt <= LP_V_LAST;
      r_raw   <= LP_IDLE;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_raw   <= w_raw_nxt;
    end
  end

  vga_if_timing_sync_dly #(
    .p_DEPTH   (p_PIPE_DLY + 1),
    .p_RST_VAL (LP_IDLE)
  ) u_sync_dly (
    .VGA_CLK  (VGA_CLK),
    .RST_N    (RST_N),
    .i_d      (r_raw),
    .o_q      (w_dly),
    .o_tap_en (w_tap_en)
  );

  // Capture returned pixel only for requested positions; blanking is exact zero.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N)        r_rgb <= '0;
    else if (w_tap_en) r_rgb <= VGA_BUF_RGB;
    else               r_rgb <= '0;
  end

  assign VGA_IF_RGBEN = r_raw.en;
  assign VGA_HS       = w_dly.hs;
  assign VGA_VS       = w_dly.vs;
  assign VGA_BLANK_N  = w_dly.en;
  assign VGA_R        = r_rgb[23:16];
  assign VGA_G        = r_rgb[15:8];
  assign VGA_B        = r_rgb[7:0];

endmodule

// File: tb/tb_vga_if_timing.sv
// Bench for vga_if_timing: two reduced-timing instances plus one default instance,
// each compared every cycle against an arithmetic model of position vs. time.
module tb_vga_if_timing;

  typedef struct packed {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    int d;  int pol;
  } cfg_t;

  localparam cfg_t C0 = '{ha:16, hfp:2, hsw:3, hbp:4, va:8, vfp:1, vsw:2, vbp:3, d:2, pol:0};
  localparam cfg_t C1 = '{ha:16, hfp:2, hsw:3, hbp:4, va:8, vfp:1, vsw:2, vbp:3, d:1, pol:1};
  localparam cfg_t C2 = '{ha:1024, hfp:24, hsw:136, hbp:160, va:768, vfp:3, vsw:6, vbp:29, d:2, pol:0};

  cfg_t cfg [3];

  logic        VGA_CLK = 1'b0;
  logic        RST_N   = 1'b0;
  logic [23:0] bufd [3];
  logic        en  [3];
  logic        hs  [3];
  logic        vs  [3];
  logic        bl  [3];
  logic [7:0]  r [3], g [3], b [3];
  logic [27:0] obs [3];

  int t       = -1;
  bit running = 1'b0;
  bit ff_mode = 1'b0;
  bit ff_drv  = 1'b0;
  bit ff_last = 1'b0;
  int n_cmp   = 0;
  int n_err   = 0;

  always #5 VGA_CLK = ~VGA_CLK;

  vga_if_timing #(
    .p_H_ACTIVE(C0.ha), .p_H_FP(C0.hfp), .p_H_SYNC(C0.hsw), .p_H_BP(C0.hbp),
    .p_V_ACTIVE(C0.va), .p_V_FP(C0.vfp), .p_V_SYNC(C0.vsw), .p_V_BP(C0.vbp),
    .p_SYNC_POL(C0.pol), .p_PIPE_DLY(C0.d)
  ) dut0 (
    .VGA_CLK(VGA_CLK), .RST_N(RST_N), .VGA_BUF_RGB(bufd[0]), .VGA_IF_RGBEN(en[0]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bl[0]), .VGA_R(r[0]), .VGA_G(g[0]), .VGA_B(b[0])
  );

  vga_if_timing #(
    .p_H_ACTIVE(C1.ha), .p_H_FP(C1.hfp), .p_H_SYNC(C1.hsw), .p_H_BP(C1.hbp),
    .p_V_ACTIVE(C1.va), .p_V_FP(C1.vfp), .p_V_SYNC(C1.vsw), .p_V_BP(C1.vbp),
    .p_SYNC_POL(C1.pol), .p_PIPE_DLY(C1.d)
  ) dut1 (
    .VGA_CLK(VGA_CLK), .RST_N(RST_N), .VGA_BUF_RGB(bufd[1]), .VGA_IF_RGBEN(en[1]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bl[1]), .VGA_R(r[1]), .VGA_G(g[1]), .VGA_B(b[1])
  );

  vga_if_timing dut2 (
    .VGA_CLK(VGA_CLK), .RST_N(RST_N), .VGA_BUF_RGB(bufd[2]), .VGA_IF_RGBEN(en[2]),
    .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_BLANK_N(bl[2]), .VGA_R(r[2]), .VGA_G(g[2]), .VGA_B(b[2])
  );

  assign obs[0] = {en[0], bl[0], hs[0], vs[0], r[0], g[0], b[0]};
  assign obs[1] = {en[1], bl[1], hs[1], vs[1], r[1], g[1], b[1]};
  assign obs[2] = {en[2], bl[2], hs[2], vs[2], r[2], g[2], b[2]};

  // ---------------- reference model: position is a pure function of time ----
  function automatic int htot(cfg_t c); return c.ha + c.hfp + c.hsw + c.hbp; endfunction
  function automatic int vtot(cfg_t c); return c.va + c.vfp + c.vsw + c.vbp; endfunction
  function automatic int pos_x(cfg_t c, int s); return s % htot(c); endfunction
  function automatic int pos_y(cfg_t c, int s); return (s / htot(c)) % vtot(c); endfunction

  function automatic bit m_en(cfg_t c, int s);
    if (s < 0) return 1'b0;
    return (pos_x(c, s) < c.ha) && (pos_y(c, s) < c.va);
  endfunction

  function automatic logic m_hs(cfg_t c, int s);
    bit act;
    act = (s >= 0) && (pos_x(c, s) >= c.ha + c.hfp) && (pos_x(c, s) < c.ha + c.hfp + c.hsw);
    return (c.pol != 0) ? act : !act;
  endfunction

  function automatic logic m_vs(cfg_t c, int s);
    bit act;
    act = (s >= 0) && (pos_y(c, s) >= c.va + c.vfp) && (pos_y(c, s) < c.va + c.vfp + c.vsw);
    return (c.pol != 0) ? act : !act;
  endfunction

  function automatic logic [23:0] m_pix(cfg_t c, int s);
    logic [7:0] xb, yb;
    xb = 8'(pos_x(c, s));
    yb = 8'(pos_y(c, s));
    return {xb, yb, 8'hA5};
  endfunction

  // What the display stage returns in cycle tt: pixel requested D cycles ago, else junk.
  function automatic logic [23:0] drv(cfg_t c, int tt);
    if (m_en(c, tt - c.d)) return m_pix(c, tt - c.d);
    return 24'($urandom);
  endfunction

  // Expected {RGBEN, BLANK_N, HS, VS, RGB} in cycle tt; outputs show position tt-(D+1).
  function automatic logic [27:0] exp_vec(cfg_t c, int tt, bit ff);
    int s;
    logic bn;
    logic [23:0] rgb;
    s   = tt - c.d - 1;
    bn  = m_en(c, s);
    rgb = '0;
    if (bn) rgb = ff ? 24'hFFFFFF : m_pix(c, s);
    return {m_en(c, tt), bn, m_hs(c, s), m_vs(c, s), rgb};
  endfunction

  // One clock: advance time, drive display returns after the edge, settle to negedge.
  task automatic step();
    @(posedge VGA_CLK);
    if (running) t++;
    ff_last = ff_drv;
    ff_drv  = ff_mode;
    #1;
    for (int k = 0; k < 3; k++) bufd[k] = ff_drv ? 24'hFFFFFF : drv(cfg[k], t);
    @(negedge VGA_CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [27:0] e;
    RST_N = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(cfg[k], -1, 1'b0);
        n_cmp++;
        if (obs[k] !== e) begin
          n_err++;
          $display("FAIL reset dut%0d got=%h want=%h", k, obs[k], e);
        end
      end
    end
    RST_N   = 1'b1;
    running = 1'b1;
  endtask

  task automatic test_frame();
    logic [27:0] e;
    int frame, en_cnt, hs_first0, hs_first1, hs_w, vs_low, L0;
    frame = htot(cfg[0]) * vtot(cfg[0]);
    L0 = cfg[0].d + 1;
    en_cnt = 0; hs_first0 = -1; hs_first1 = -1; hs_w = 0; vs_low = 0;
    for (int n = 0; n < frame + L0 + htot(cfg[0]); n++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(cfg[k], t, ff_last);
        n_cmp++;
        if (obs[k] !== e) begin
          n_err++;
          $display("FAIL frame dut%0d t=%0d got=%h want=%h", k, t, obs[k], e);
        end
      end
      if (t < frame && en[0]) en_cnt++;
      if (hs_first0 < 0 && hs[0] == 1'b0) hs_first0 = t;
      if (hs_first1 < 0 && hs[1] == 1'b1) hs_first1 = t;
      if (t >= L0 && t < L0 + htot(cfg[0]) && hs[0] == 1'b0) hs_w++;
      if (t >= L0 && t < L0 + frame && vs[0] == 1'b0) vs_low++;
    end
    n_cmp++;
    if (en_cnt !== cfg[0].ha * cfg[0].va) begin
      n_err++; $display("FAIL rgben_count got=%0d want=%0d", en_cnt, cfg[0].ha * cfg[0].va);
    end
    n_cmp++;
    if (hs_first0 !== cfg[0].ha + cfg[0].hfp + L0) begin
      n_err++; $display("FAIL hs_start got=%0d want=%0d", hs_first0, cfg[0].ha + cfg[0].hfp + L0);
    end
    n_cmp++;
    if (hs_first1 !== cfg[1].ha + cfg[1].hfp + cfg[1].d + 1) begin
      n_err++; $display("FAIL hs_start_pol1 got=%0d want=%0d", hs_first1, cfg[1].ha + cfg[1].hfp + cfg[1].d + 1);
    end
    n_cmp++;
    if (hs_w !== cfg[0].hsw) begin
      n_err++; $display("FAIL hs_width got=%0d want=%0d", hs_w, cfg[0].hsw);
    end
    n_cmp++;
    if (vs_low !== cfg[0].vsw * htot(cfg[0])) begin
      n_err++; $display("FAIL vs_width got=%0d want=%0d", vs_low, cfg[0].vsw * htot(cfg[0]));
    end
  endtask

  task automatic test_blank_ff();
    logic [27:0] e;
    ff_mode = 1'b1;
    for (int n = 0; n < htot(cfg[0]) * vtot(cfg[0]) + 5; n++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(cfg[k], t, ff_last);
        n_cmp++;
        if (obs[k] !== e) begin
          n_err++;
          $display("FAIL blank_ff dut%0d t=%0d got=%h want=%h", k, t, obs[k], e);
        end
      end
    end
    ff_mode = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [27:0] e;
    int rx, ry, budget;
    bit found;
    for (int rep = 0; rep < 2; rep++) begin
      rx = $urandom_range(0, htot(cfg[0]) - 1);
      ry = (rep == 0) ? cfg[0].va + cfg[0].vfp : $urandom_range(0, vtot(cfg[0]) - 1);
      budget = 2 * htot(cfg[0]) * vtot(cfg[0]);
      found = 1'b0;
      for (int n = 0; n < budget && !found; n++) begin
        step();
        found = (pos_x(cfg[0], t) == rx) && (pos_y(cfg[0], t) == ry);
      end
      n_cmp++;
      if (!found) begin
        n_err++;
        $display("FAIL mid_reset_seek got=timeout want=(%0d,%0d)", rx, ry);
      end
      RST_N   = 1'b0;
      running = 1'b0;
      t       = -1;
      #1;
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(cfg[k], -1, 1'b0);
        n_cmp++;
        if (obs[k] !== e) begin
          n_err++;
          $display("FAIL mid_reset_async dut%0d got=%h want=%h", k, obs[k], e);
        end
      end
      for (int n = 0; n < 3; n++) step();
      RST_N   = 1'b1;
      running = 1'b1;
      for (int n = 0; n < htot(cfg[0]) * vtot(cfg[0]) + 10; n++) begin
        step();
        for (int k = 0; k < 3; k++) begin
          e = exp_vec(cfg[k], t, ff_last);
          n_cmp++;
          if (obs[k] !== e) begin
            n_err++;
            $display("FAIL mid_reset_frame dut%0d t=%0d got=%h want=%h", k, t, obs[k], e);
          end
        end
      end
    end
  endtask

  task automatic test_default_lines();
    logic [27:0] e;
    for (int n = 0; n < 2 * htot(cfg[2]) + 40; n++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(cfg[k], t, ff_last);
        n_cmp++;
        if (obs[k] !== e) begin
          n_err++;
          $display("FAIL default_lines dut%0d t=%0d got=%h want=%h", k, t, obs[k], e);
        end
      end
    end
  endtask

  initial begin
    cfg[0] = C0;
    cfg[1] = C1;
    cfg[2] = C2;
    for (int k = 0; k < 3; k++) bufd[k] = '0;
    test_reset();
    test_frame();
    test_blank_ff();
    test_mid_reset();
    test_default_lines();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_if_timing.md
VGA_IF_TIMING -- requirements
Module: VGA_IF_TIMING

Interface
REQ-001 SHALL have parameter p_H_ACTIVE, default 1024, active pixels per line.
REQ-002 SHALL have parameter p_H_FP / p_H_SYNC / p_H_BP, defaults 24 / 136 / 160, horizontal porch and sync widths in pixels (line total 1344).
REQ-003 SHALL have parameter p_V_ACTIVE, default 768, active lines per frame.
REQ-004 SHALL have parameter p_V_FP / p_V_SYNC / p_V_BP, defaults 3 / 6 / 29, vertical porch and sync widths in lines (frame total 806).
REQ-005 SHALL have parameter p_SYNC_POL, default 0, sync polarity (0 = active-low, 1 = active-high).
REQ-006 SHALL have parameter p_PIPE_DLY, default 2, range 1..8, cycles from VGA_IF_RGBEN high to matching VGA_BUF_RGB valid.
REQ-007 SHALL have port VGA_CLK, input, 1, pixel clock (65 MHz for default timing).
REQ-008 SHALL have port RST_N, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port VGA_BUF_RGB, input, 24, pixel from display stage, {R[23:16],G[15:8],B[7:0]}.
REQ-010 SHALL have port VGA_IF_RGBEN, output, 1, pixel request to display stage.
REQ-011 SHALL have ports VGA_HS and VGA_VS, outputs, 1 each, syncs to connector.
REQ-012 SHALL have port VGA_BLANK_N, output, 1, DAC blank (low = blank).
REQ-013 SHALL have ports VGA_R, VGA_G, VGA_B, outputs, 8 each, DAC pixel data.

Function
REQ-014 SHALL keep 11-bit counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1); h_cnt increments every cycle and wraps to 0 after H_TOTAL-1; v_cnt increments only on that h wrap and wraps to 0 after V_TOTAL-1.
REQ-015 SHALL set VGA_IF_RGBEN, a flop output, high exactly in cycles where h_cnt < p_H_ACTIVE and v_cnt < p_V_ACTIVE (1024 x 768 = 786432 highs per frame).
REQ-016 SHALL assert raw HS for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([1048,1183]) and raw VS for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] ([771,776]), polarity per p_SYNC_POL.
REQ-017 SHALL delay raw HS, raw VS and VGA_IF_RGBEN by p_PIPE_DLY+1 cycles to produce VGA_HS, VGA_VS and VGA_BLANK_N respectively.
REQ-018 SHALL register VGA_BUF_RGB into VGA_R/G/B at the end of cycle k+p_PIPE_DLY when VGA_IF_RGBEN was high in cycle k; otherwise load 0.
REQ-019 SHALL align outputs so VGA_R/G/B, VGA_BLANK_N, VGA_HS, VGA_VS for a given counter position appear in the same cycle; total latency p_PIPE_DLY+1.
REQ-020 SHALL ignore VGA_BUF_RGB whenever the delayed enable is low (blanking outputs exactly 0).
REQ-021 SHALL not stall or back-pressure; timing is free-running.

Reset
REQ-022 SHALL, on RST_N low, asynchronously load h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1 so the first clock edge after release yields (0,0) and VGA_IF_RGBEN high.
REQ-023 SHALL, during reset, hold VGA_IF_RGBEN = 0, VGA_BLANK_N = 0, VGA_R/G/B = 0, all delay stages cleared, VGA_HS/VGA_VS at inactive level.
REQ-024 SHALL treat reset mid-frame identically to power-on; the next frame starts from (0,0) with no partial sync pulse emitted.

Structure
REQ-025 SHALL take default timing constants (active, porches, sync widths, totals for 1024x768@60) from shared package VGA_PKG, also used by the display stage.
REQ-026 SHALL implement the p_PIPE_DLY+1-deep 3-bit delay line (HS, VS, enable) as sub-module VGA_SYNC_DLY with parameterised depth and reset-to-inactive values.

Verification
REQ-027 SHALL check: release reset -> VGA_IF_RGBEN high on first edge, 1024 cycles high, 320 low, repeating for 768 lines, then 38 low lines.
REQ-028 SHALL check: VGA_HS low 136 cycles starting 1048+p_PIPE_DLY+1 cycles after first RGBEN rise; VGA_VS low 6 lines (8064 cycles); frame period 1083264 cycles.
REQ-029 SHALL check: model display with p_PIPE_DLY=2 returning {X[7:0],Y[7:0],8'hA5} -> VGA_R/G/B match pixel (x,y) in the cycle VGA_BLANK_N is high for that pixel, first pixel 3 cycles after RGBEN rise.
REQ-030 SHALL check: VGA_BUF_RGB forced to 24'hFFFFFF constantly -> VGA_R/G/B = 0 whenever VGA_BLANK_N = 0.
REQ-031 SHALL check: RST_N pulsed low at h_cnt=500, v_cnt=300 -> outputs at reset values immediately; after release, full frame from (0,0) with correct counts.
REQ-032 SHALL check: p_SYNC_POL=1, p_PIPE_DLY=1 -> sync pulses inverted, same widths, latency 2 cycles.
